pim_indirect_addr_gen: RTL and testbench
========================================

// Module: pim_indirect_addr_gen
// PURPOSE
//  Downstream consumer of the indirect-argument registers (A/B/C base addresses).
//  On a start pulse, latches the three bases and walks N elements. Per element it issues
//  three requests to the PIM command path over a valid/ready interface:
//  read A[idx], read B[idx], write C[idx]. Reports busy and done to the host-side control.
// PARAMETERS
//  ADDR_W        32   width of base/args and request addresses
//  CNT_W         16   width of element count and index
//  STRIDE_BYTES  32   byte increment per element (one 256-bit burst)
// PORTS
//  clk               in   1       clock
//  rst_x             in   1       reset, synchronous, active-high
//  i_args_reg_A      in   ADDR_W  operand A base address
//  i_args_reg_B      in   ADDR_W  operand B base address
//  i_args_reg_C      in   ADDR_W  result C base address
//  i_num_elem        in   CNT_W   element count, sampled at start
//  i_start           in   1       start pulse
//  i_PIM_dev_working in   1       start is accepted only when 1
//  i_HPC_clear       in   1       abort/clear
//  o_req_valid       out  1       request valid
//  i_req_ready       in   1       request accepted when valid&ready
//  o_req_addr        out  ADDR_W  request byte address
//  o_req_wr          out  1       0=read (A,B), 1=write (C)
//  o_req_sel         out  2       operand tag: 0=A, 1=B, 2=C
//  o_req_idx         out  CNT_W   element index of current request
//  o_busy            out  1       1 in any state except IDLE
//  o_done            out  1       one-cycle pulse on completion
// BEHAVIOUR
//  Reset (rst_x=1 at clk edge): state=IDLE; all outputs 0; index and offset counters 0.
//  FSM states: IDLE, RD_A, RD_B, WR_C, DONE.
//  IDLE:
//   - i_start & i_PIM_dev_working & !i_HPC_clear: latch A/B/C bases and i_num_elem;
//     clear idx and offset.
//   - Next state is RD_A, or DONE if num_elem==0 (no requests issued).
//   - i_start while not IDLE is ignored. i_start with i_PIM_dev_working=0 is ignored.
//  RD_A/RD_B/WR_C:
//   - o_req_valid=1 for the whole state.
//   - addr = base_{A|B|C} + offset.
//   - wr=1 only in WR_C; sel=0/1/2; idx=current index.
//   - Advance to the next state only on valid&ready.
//     Order: RD_A -> RD_B -> WR_C.
//   - On the WR_C handshake: idx+=1 and offset+=STRIDE_BYTES.
//     Go to DONE if idx+1==num_elem, else back to RD_A.
//   - addr/wr/sel/idx are registered and stay stable while valid&!ready (no drop, no change).
//  DONE: o_done=1 for exactly one cycle; o_busy=1; next state IDLE.
//  Latency:
//   - Start accepted at edge t -> o_req_valid=1 from t+1.
//   - Back-to-back requests at 1 per cycle while ready=1.
//   - N elements with ready always 1: 3N request cycles, then the o_done cycle.
//  Arithmetic:
//   - offset is accumulated, no multiplier.
//   - base+offset wraps modulo 2^ADDR_W.
//   - idx counts 0..num_elem-1 and never wraps within a run.
//  Later changes to i_args_reg_* or i_num_elem during a run have no effect (values latched at start).
//  i_HPC_clear (any state, priority over everything except reset):
//   - Next cycle: IDLE, o_req_valid=0, counters 0, no o_done.
//   - An in-flight valid is withdrawn even without ready.
//  Simultaneous i_HPC_clear and i_start in IDLE: clear wins, start is dropped.
//  Reset mid-run behaves the same as clear.
// TESTING
//  T1: A=0x1000_0000, B=0x2000_0000, C=0x3000_0000, N=2, ready=1
//      -> reads A 0x1000_0000, B 0x2000_0000; write C 0x3000_0000;
//         then 0x1000_0020, 0x2000_0020, 0x3000_0020;
//         o_done pulses 7 cycles after the start edge.
//  T2: N=0, start -> no o_req_valid; o_done=1 on cycle t+1; o_busy=1 on cycle t+1 only.
//  T3: N=1, ready=0 for 5 cycles on RD_B
//      -> addr/sel/idx stable and valid held 5 cycles; RD_B then WR_C complete after ready.
//  T4: A=0xFFFF_FFF0, N=2 -> second RD_A addr=0x0000_0010 (wrap).
//  T5: N=4, i_HPC_clear at idx=2 in RD_B
//      -> valid=0 next cycle, state IDLE, no o_done;
//         a new start then restarts at idx 0 with the newly latched bases.
//  T6: start with i_PIM_dev_working=0, or start while busy -> ignored; request stream unchanged.

Source files
------------

// File: rtl/pim_indirect_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : pim_indirect_addr_gen
// Description : Walks N elements from latched A/B/C base addresses. For each
//               element it issues read A[idx], read B[idx] and write C[idx]
//               over a valid/ready request port. It also reports busy and
//               pulses done when the walk completes.
// Revision    : 1.0 - initial release
// ============================================================================
module pim_indirect_addr_gen #(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 16,
  parameter int STRIDE_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic [ADDR_W-1:0] i_args_reg_A,
  input  logic [ADDR_W-1:0] i_args_reg_B,
  input  logic [ADDR_W-1:0] i_args_reg_C,
  input  logic [CNT_W-1:0]  i_num_elem,
  input  logic              i_start,
  input  logic              i_PIM_dev_working,
  input  logic              i_HPC_clear,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic              o_req_wr,
  output logic [1:0]        o_req_sel,
  output logic [CNT_W-1:0]  o_req_idx,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR_C = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(STRIDE_BYTES);
  localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [ADDR_W-1:0] base_c_q, base_c_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  ridx_q, ridx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs;

  assign hs = valid_q & i_req_ready;

  // Next-state, latched operands and the index/offset counters; clear overrides all.
  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    num_d    = num_q;
    idx_d    = idx_q;
    off_d    = off_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && i_PIM_dev_working) begin
          base_a_d = i_args_reg_A;
          base_b_d = i_args_reg_B;
          base_c_d = i_args_reg_C;
          num_d    = i_num_elem;
          idx_d    = '0;
          off_d    = '0;
          state_d  = (i_num_elem == '0) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: if (hs) state_d = S_RD_B;
      S_RD_B: if (hs) state_d = S_WR_C;
      S_WR_C: begin
        if (hs) begin
          idx_d   = idx_q + C_ONE;
          off_d   = off_q + C_STRIDE;
          state_d = ((idx_q + C_ONE) == num_q) ? S_DONE : S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_HPC_clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
      off_d   = '0;
    end
  end

  // Request and status outputs are decoded from the next state so they are flop-driven.
  always_comb begin
    valid_d = 1'b0;
    addr_d  = '0;
    wr_d    = 1'b0;
    sel_d   = 2'd0;
    ridx_d  = '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    case (state_d)
      S_RD_A: begin
        valid_d = 1'b1;
        addr_d  = base_a_d + off_d;
        sel_d   = 2'd0;
        ridx_d  = idx_d;
      end
      S_RD_B: begin
        valid_d = 1'b1;
        addr_d  = base_b_d + off_d;
        sel_d   = 2'd1;
        ridx_d  = idx_d;
      end
      S_WR_C: begin
        valid_d = 1'b1;
        addr_d  = base_c_d + off_d;
        wr_d    = 1'b1;
        sel_d   = 2'd2;
        ridx_d  = idx_d;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // State, operand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_x) begin
      state_q  <= S_IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      num_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      sel_q    <= 2'd0;
      ridx_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      ridx_q   <= ridx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_req_valid = valid_q;
  assign o_req_addr  = addr_q;
  assign o_req_wr    = wr_q;
  assign o_req_sel   = sel_q;
  assign o_req_idx   = ridx_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pim_indirect_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pim_indirect_addr_gen
// Description : Directed self-checking bench for pim_indirect_addr_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pim_indirect_addr_gen;

  logic        clk = 1'b0;
  logic        rst_x;
  logic [31:0] i_args_reg_A, i_args_reg_B, i_args_reg_C;
  logic [15:0] i_num_elem;
  logic        i_start, i_PIM_dev_working, i_HPC_clear, i_req_ready;
  logic        o_req_valid, o_req_wr, o_busy, o_done;
  logic [31:0] o_req_addr;
  logic [1:0]  o_req_sel;
  logic [15:0] o_req_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pim_indirect_addr_gen #(.ADDR_W(32), .CNT_W(16), .STRIDE_BYTES(32)) dut (
    .clk(clk), .rst_x(rst_x),
    .i_args_reg_A(i_args_reg_A), .i_args_reg_B(i_args_reg_B), .i_args_reg_C(i_args_reg_C),
    .i_num_elem(i_num_elem), .i_start(i_start), .i_PIM_dev_working(i_PIM_dev_working),
    .i_HPC_clear(i_HPC_clear), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_addr(o_req_addr), .o_req_wr(o_req_wr), .o_req_sel(o_req_sel),
    .o_req_idx(o_req_idx), .o_busy(o_busy), .o_done(o_done)
  );

  // Packed view: {valid, wr, sel[1:0], idx[15:0], addr[31:0], done, busy}
  function automatic logic [53:0] obs();
    return {o_req_valid, o_req_wr, o_req_sel, o_req_idx, o_req_addr, o_done, o_busy};
  endfunction

  function automatic logic [53:0] req(input logic [1:0] sel, input logic [15:0] idx,
                                      input logic [31:0] addr);
    return {1'b1, (sel == 2'd2), sel, idx, addr, 1'b0, 1'b1};
  endfunction

  localparam logic [53:0] C_IDLE = 54'd0;
  localparam logic [53:0] C_DONE = 54'd3;  // done=1, busy=1

  // Pulse start for one edge; returns at the negedge of the first cycle after acceptance.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [15:0] n);
    i_args_reg_A = a; i_args_reg_B = b; i_args_reg_C = c; i_num_elem = n;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_x = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL reset: got %h want %h", obs(), C_IDLE);
    end
    rst_x = 1'b0;
    @(negedge clk);
  endtask

  // N=2 walk with ready held high; done follows six request cycles.
  task automatic test_stream();
    logic [31:0] base [3];
    logic [53:0] e;
    base[0] = 32'h1000_0000; base[1] = 32'h2000_0000; base[2] = 32'h3000_0000;
    do_start(base[0], base[1], base[2], 16'd2);
    for (int k = 0; k < 6; k++) begin
      e = req(2'(k % 3), 16'(k / 3), base[k % 3] + 32'(32 * (k / 3)));
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL stream k=%0d: got %h want %h", k, obs(), e);
      end
      @(negedge clk);
    end
    checks++;
    if (obs() !== C_DONE) begin
      errors++; $display("FAIL stream done: got %h want %h", obs(), C_DONE);
    end
    @(negedge clk);
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL stream idle after done: got %h want %h", obs(), C_IDLE);
    end
  endtask

  task automatic test_zero_elem();
    do_start(32'hA, 32'hB, 32'hC, 16'd0);
    checks++;
    if (obs() !== C_DONE) begin
      errors++; $display("FAIL zero_elem done: got %h want %h", obs(), C_DONE);
    end
    @(negedge clk);
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL zero_elem idle: got %h want %h", obs(), C_IDLE);
    end
  endtask

  task automatic test_backpressure();
    logic [53:0] e;
    do_start(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 16'd1);
    e = req(2'd0, 16'd0, 32'h1000_0000);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL bp rd_a: got %h want %h", obs(), e);
    end
    @(negedge clk);
    i_req_ready = 1'b0;
    e = req(2'd1, 16'd0, 32'h2000_0000);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL bp hold k=%0d: got %h want %h", k, obs(), e);
      end
      @(negedge clk);
    end
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL bp hold end: got %h want %h", obs(), e);
    end
    i_req_ready = 1'b1;
    @(negedge clk);
    e = req(2'd2, 16'd0, 32'h3000_0000);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL bp wr_c: got %h want %h", obs(), e);
    end
    @(negedge clk);
    checks++;
    if (obs() !== C_DONE) begin
      errors++; $display("FAIL bp done: got %h want %h", obs(), C_DONE);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [53:0] e;
    do_start(32'hFFFF_FFF0, 32'h2000_0000, 32'h3000_0000, 16'd2);
    e = req(2'd0, 16'd0, 32'hFFFF_FFF0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL wrap first: got %h want %h", obs(), e);
    end
    repeat (3) @(negedge clk);
    e = req(2'd0, 16'd1, 32'h0000_0010);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL wrap second: got %h want %h", obs(), e);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clear();
    logic [53:0] e;
    logic        saw_done;
    do_start(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 16'd4);
    repeat (7) @(negedge clk);
    e = req(2'd1, 16'd2, 32'h2000_0040);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL clear pre: got %h want %h", obs(), e);
    end
    i_HPC_clear = 1'b1;
    i_req_ready = 1'b0;
    @(negedge clk);
    i_HPC_clear = 1'b0;
    i_req_ready = 1'b1;
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL clear post: got %h want %h", obs(), C_IDLE);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | o_done | o_busy;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL clear quiet: got %b want 0", saw_done);
    end
    do_start(32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 16'd1);
    e = req(2'd0, 16'd0, 32'h4000_0000);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL clear restart: got %h want %h", obs(), e);
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    logic [53:0] e;
    i_PIM_dev_working = 1'b0;
    do_start(32'h7000_0000, 32'h7100_0000, 32'h7200_0000, 16'd1);
    i_PIM_dev_working = 1'b1;
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL start_not_working: got %h want %h", obs(), C_IDLE);
    end
    i_HPC_clear = 1'b1;
    do_start(32'h7000_0000, 32'h7100_0000, 32'h7200_0000, 16'd1);
    i_HPC_clear = 1'b0;
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL start_with_clear: got %h want %h", obs(), C_IDLE);
    end
    do_start(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 16'd1);
    // Restart with different operands while busy; the stream must not change.
    do_start(32'h8000_0000, 32'h8100_0000, 32'h8200_0000, 16'd5);
    e = req(2'd1, 16'd0, 32'h2000_0000);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL busy_start rd_b: got %h want %h", obs(), e);
    end
    @(negedge clk);
    e = req(2'd2, 16'd0, 32'h3000_0000);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL busy_start wr_c: got %h want %h", obs(), e);
    end
    @(negedge clk);
    checks++;
    if (obs() !== C_DONE) begin
      errors++; $display("FAIL busy_start done: got %h want %h", obs(), C_DONE);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    do_start(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 16'd3);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    rst_x = 1'b0;
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL reset_midrun: got %h want %h", obs(), C_IDLE);
    end
    @(negedge clk);
    checks++;
    if (obs() !== C_IDLE) begin
      errors++; $display("FAIL reset_midrun stay: got %h want %h", obs(), C_IDLE);
    end
  endtask

  initial begin
    rst_x = 1'b1;
    i_args_reg_A = '0; i_args_reg_B = '0; i_args_reg_C = '0; i_num_elem = '0;
    i_start = 1'b0; i_PIM_dev_working = 1'b1; i_HPC_clear = 1'b0; i_req_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_zero_elem();
    test_backpressure();
    test_wrap();
    test_clear();
    test_ignored_start();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
